// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding, pipeline depth and width helper for the MAC dot-product sequencer.
package mac_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int PIPE_LAT = 2;
    function automatic int acc_width(input int dw, input int lw);
        return 2 * dw + lw;
    endfunction
endpackage

// File: rtl/mac_dot_sequencer_if.sv
// mac_dot_sequencer_if: command, operand stream and result handshakes of the dot-product sequencer.
interface mac_dot_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + LEN_WIDTH
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] b_in;
    logic [DATA_WIDTH-1:0] c_in;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    modport master (
        output start, len, in_valid, b_in, c_in, res_ready,
        input  busy, in_ready, res_valid, res_data
    );
    modport slave (
        input  start, len, in_valid, b_in, c_in, res_ready,
        output busy, in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_acc_core.sv
// mac_acc_core: two-stage unsigned MAC, registered product followed by registered accumulate.
module mac_acc_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [ACC_WIDTH-1:0]  acc
);
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic                    r_pv;
    logic [ACC_WIDTH-1:0]    r_acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_pv <= issue;
            if (issue) r_prod <= b * c;
            r_acc <= clear ? '0 : r_pv ? r_acc + ACC_WIDTH'(r_prod) : r_acc;
        end
    end
    assign acc = r_acc;
endmodule

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: sequences N operand beats through the MAC core, drains it and hands out the dot product.
module mac_dot_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, LEN_WIDTH)
) (
    input logic                clk,
    input logic                rst,
    mac_dot_sequencer_if.slave bus
);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    state_t               r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [DW-1:0]        r_drain;
    logic                 r_busy;
    logic                 r_in_ready;
    logic                 r_res_valid;
    logic [ACC_WIDTH-1:0] r_res_data;
    logic                 w_accept;
    logic                 w_clear;
    logic [ACC_WIDTH-1:0] w_acc;
    assign w_accept = r_in_ready & bus.in_valid;
    assign w_clear  = (r_state == S_IDLE) & bus.start;
    mac_acc_core #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .issue (w_accept),
        .b     (bus.b_in),
        .c     (bus.c_in),
        .acc   (w_acc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_beat      <= '0;
            r_drain     <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_len   <= bus.len;
                    r_beat  <= '0;
                    r_drain <= '0;
                    r_busy  <= 1'b1;
                    if (bus.len != '0) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= '0;
                    end
                end
                S_RUN: if (w_accept) begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat + 1'b1 == r_len) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    // the last product lands in the accumulator before the final drain cycle ends
                    if (r_drain == DW'(PIPE_LAT - 1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_acc;
                    end
                end
                S_DONE: if (bus.res_ready) begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.busy      = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: randomized dot-product bench against a sum-of-products reference model.
module tb_mac_dot_sequencer;
    import mac_ctrl_pkg::*;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int AW = acc_width(DW, LW);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int ob[256];
    int oc[256];
    mac_dot_sequencer_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) bus ();
    mac_dot_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic run_op(input int n, input int bubble, input int hold, input bit poke);
        logic [63:0] exp = 0;
        int idx = 0;
        int guard = 0;
        for (int i = 0; i < n; i++) exp += 64'(ob[i] * oc[i]);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(negedge clk);
        bus.start = 1'b0;
        if (n == 0) check("zero_no_ready", bus.in_ready, 0);
        else begin
            while (idx < n && guard < 4 * n + 20) begin
                check("run_ready", bus.in_ready, 1);
                check("run_busy", bus.busy, 1);
                bus.in_valid = (bubble == 0) ? 1'b1 : (bubble == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
                bus.b_in = bus.in_valid ? DW'(ob[idx]) : DW'($urandom);
                bus.c_in = bus.in_valid ? DW'(oc[idx]) : DW'($urandom);
                @(negedge clk);
                if (bus.in_valid) idx++;
                guard++;
            end
            check("beats", 64'(idx), 64'(n));
            bus.in_valid = 1'b0;
            for (int d = 0; d < PIPE_LAT; d++) begin
                check("drain_ready", bus.in_ready, 0);
                check("drain_valid", bus.res_valid, 0);
                check("drain_busy", bus.busy, 1);
                @(negedge clk);
            end
        end
        for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            bus.start = poke;
            bus.len = 8'd5;
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", 64'(bus.res_data), exp);
            check("hold_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        check("done_valid", bus.res_valid, 1);
        check("done_busy", bus.busy, 1);
        check("done_data", 64'(bus.res_data), exp);
        bus.res_ready = 1'b1;
        bus.start = poke;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start = 1'b0;
        check("after_valid", bus.res_valid, 0);
        check("after_busy", bus.busy, 0);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.in_ready, 0);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.b_in = '0;
        bus.c_in = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.in_ready, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_data", 64'(bus.res_data), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin ob[i] = 2 * i + 1; oc[i] = 2 * i + 2; end
        run_op(4, 0, 0, 1'b0);
        for (int i = 0; i < 255; i++) begin ob[i] = 255; oc[i] = 255; end
        run_op(255, 0, 0, 1'b0);
        ob[0] = 2; oc[0] = 3; ob[1] = 4; oc[1] = 5; ob[2] = 6; oc[2] = 7;
        run_op(3, 1, 0, 1'b0);
        ob[0] = 10; oc[0] = 10; ob[1] = 1; oc[1] = 1;
        run_op(2, 0, 5, 1'b1);
        run_op(0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin ob[i] = 200; oc[i] = 200; end
        bus.start = 1'b1;
        bus.len = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.b_in = 8'd200;
        bus.c_in = 8'd200;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.in_ready, 0);
        check("abort_valid", bus.res_valid, 0);
        check("abort_data", 64'(bus.res_data), 0);
        rst = 1'b0;
        @(negedge clk);
        ob[0] = 9; oc[0] = 9;
        run_op(1, 0, 0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin ob[i] = $urandom_range(0, 255); oc[i] = $urandom_range(0, 255); end
            run_op(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Controller that sequences a pipelined multiply-accumulate datapath to compute one unsigned dot product of a programmable length N.
- Accepts a start command with a length, streams N operand pairs in over a valid/ready handshake, drains the pipeline, then presents the result over a valid/ready handshake.
- Sits between the operand-fetch logic and the result consumer, and owns clearing and enabling of its internal MAC core.

Parameters:
- DATA_WIDTH, 8, width of each unsigned operand b and c.
- LEN_WIDTH, 8, width of the length field; maximum N = 2^LEN_WIDTH-1.
- ACC_WIDTH, 2*DATA_WIDTH+LEN_WIDTH, accumulator and result width; guarantees no overflow at maximum N.

Ports:
- clk  in  1  system clock; every register is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_WIDTH  vector length N; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in RUN.
- b_in  in  DATA_WIDTH  operand B.
- c_in  in  DATA_WIDTH  operand C.
- res_valid  out  1  result valid; high only in DONE.
- res_ready  in  1  consumer accepts the result.
- res_data  out  ACC_WIDTH  dot product sum of b_i*c_i.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy, in_ready and res_valid are 0; res_data, accumulator, beat counter and drain counter are 0. Reset has priority over all other inputs and aborts any operation in flight.
- States: IDLE, RUN, DRAIN, DONE. State encoding is one-hot or binary; only the named states are legal.
- IDLE:
  - If start=1 and len!=0: latch len, clear the accumulator and counters, next state RUN.
  - If start=1 and len==0: clear the accumulator, next state DONE; res_data=0.
  - in_valid is ignored.
- RUN:
  - in_ready=1. A beat is accepted when in_valid&in_ready. Each accepted pair is issued to the core.
  - Bubbles (in_valid=0) stall the sequencer without side effects.
  - On the accept of beat N, next state DRAIN.
- DRAIN: in_ready=0. Stays exactly PIPE_LAT=2 cycles, then DONE.
- DONE:
  - res_valid=1; res_data is held stable until res_ready=1.
  - On res_valid&res_ready, next state IDLE.
  - start is ignored in every state except IDLE. A start arriving in the same cycle as the handshake is dropped; the earliest accepted start is the following cycle.
- Core timing:
  - Product register is loaded in the cycle after the accept.
  - Accumulator adds the product one cycle later.
  - Arithmetic is unsigned and zero-extended to ACC_WIDTH; no wrap is possible.
- Latency: start accepted at cycle 0 with in_valid held high gives accepts in cycles 1..N, DRAIN in cycles N+1 and N+2, and res_valid first high in cycle N+3.
- Accumulator clear is synchronous. The core enable is asserted only on an accept, or while a product is in flight during DRAIN.

Decomposition:
- Package mac_ctrl_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - PIPE_LAT=2 constant.
  - ACC_WIDTH derivation helper.
- Sub-module mac_acc_core:
  - 2-stage pipeline: registered product, then registered accumulate.
  - Ports: clk, rst, clear, issue, b, c, acc.
  - The sequencer FSM, counters and handshakes stay in mac_dot_sequencer.

Test Plan:
- N=4, pairs (1,2),(3,4),(5,6),(7,8), in_valid always high, res_ready high -> res_data=100; res_valid is high exactly in cycle 7 for one cycle; busy falls in cycle 8.
- N=255, all operands 255 -> res_data=16581375; no overflow at ACC_WIDTH=24.
- N=3, pairs (2,3),(4,5),(6,7) with in_valid low on alternate cycles -> res_data=68; in_ready held high throughout RUN; the beat counter advances only on accepts.
- N=2, pairs (10,10),(1,1), res_ready low for 5 cycles -> res_data=101 stable for all 6 res_valid cycles; then IDLE; a start during DONE is ignored.
- start with len=0 -> res_valid=1 the next cycle with res_data=0; no in_ready pulse occurs.
- rst asserted mid-RUN after 2 of 4 beats -> the next cycle shows IDLE and all outputs 0. A new N=1 (9,9) operation then gives 81, with no residue from the aborted operation.
